// File: rtl/ceespu_ex_sequencer_if.sv
// Signal bundle between decode, the execute-stage sequencer, the ALU and writeback.
// The sequencer connects through the slave modport; decode/ALU models use master.
interface ceespu_ex_sequencer_if #(
    parameter int RD_W = 5
);
    logic            I_valid;
    logic            O_ready;
    logic [3:0]      I_aluop;
    logic [31:0]     I_dataA;
    logic [31:0]     I_dataB;
    logic            I_Cin;
    logic [RD_W-1:0] I_rd;
    logic            I_flush;
    logic [31:0]     O_alu_dataA;
    logic [31:0]     O_alu_dataB;
    logic            O_alu_Cin;
    logic [3:0]      O_alu_aluop;
    logic            I_alu_multiCycle;
    logic            I_alu_dataReady;
    logic [31:0]     I_alu_result;
    logic            I_alu_Cout;
    logic            O_stall;
    logic            O_wb_valid;
    logic [RD_W-1:0] O_wb_rd;
    logic [31:0]     O_wb_data;
    logic            O_wb_Cout;
    logic            O_timeout;

    modport master (
        output I_valid, I_aluop, I_dataA, I_dataB, I_Cin, I_rd, I_flush,
        output I_alu_multiCycle, I_alu_dataReady, I_alu_result, I_alu_Cout,
        input  O_ready, O_alu_dataA, O_alu_dataB, O_alu_Cin, O_alu_aluop,
        input  O_stall, O_wb_valid, O_wb_rd, O_wb_data, O_wb_Cout, O_timeout
    );

    modport slave (
        input  I_valid, I_aluop, I_dataA, I_dataB, I_Cin, I_rd, I_flush,
        input  I_alu_multiCycle, I_alu_dataReady, I_alu_result, I_alu_Cout,
        output O_ready, O_alu_dataA, O_alu_dataB, O_alu_Cin, O_alu_aluop,
        output O_stall, O_wb_valid, O_wb_rd, O_wb_data, O_wb_Cout, O_timeout
    );
endinterface

// File: rtl/ceespu_ex_sequencer.sv
// Execute-stage sequencer: holds ALU operands, stalls decode on multi-cycle ops and
// emits a one-cycle writeback pulse. Macro CEESPU_EXSEQ_TIMEOUT_EN adds a WAIT abort.
module ceespu_ex_sequencer #(
    parameter int RD_W    = 5,
    parameter int TIMEOUT = 15
) (
    input logic                  I_clk,
    input logic                  I_rst,
    ceespu_ex_sequencer_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WAIT} state_t;

    state_t          state;
    logic [3:0]      aluop_hold;
    logic [31:0]     a_hold;
    logic [31:0]     b_hold;
    logic            cin_hold;
    logic [RD_W-1:0] rd_hold;
    logic            wb_valid;
    logic [RD_W-1:0] wb_rd;
    logic [31:0]     wb_data;
    logic            wb_cout;
    logic            ready;
    logic            capture;

    // The wait counter is 4 bits wide, so the abort threshold must fit in it.
    if (TIMEOUT < 1 || TIMEOUT > 15) begin : g_timeout_range
        $error("TIMEOUT must fit the 4-bit wait counter");
    end

    // Flush blocks both a new accept and any result capture in the same cycle.
    always_comb begin
        ready   = 1'b0;
        capture = 1'b0;
        if (!bus.I_flush) begin
            case (state)
                S_IDLE:  ready = 1'b1;
                S_EXEC: begin
                    ready   = !bus.I_alu_multiCycle;
                    capture = !bus.I_alu_multiCycle || bus.I_alu_dataReady;
                end
                S_WAIT:  capture = bus.I_alu_dataReady;
                default: ready = 1'b0;
            endcase
        end
    end

`ifdef CEESPU_EXSEQ_TIMEOUT_EN
    logic [3:0] wait_cnt;
    logic       timeout;
`endif

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state      <= S_IDLE;
            aluop_hold <= '0;
            a_hold     <= '0;
            b_hold     <= '0;
            cin_hold   <= 1'b0;
            rd_hold    <= '0;
            wb_valid   <= 1'b0;
            wb_rd      <= '0;
            wb_data    <= '0;
            wb_cout    <= 1'b0;
`ifdef CEESPU_EXSEQ_TIMEOUT_EN
            wait_cnt   <= '0;
            timeout    <= 1'b0;
`endif
        end else begin
            wb_valid <= 1'b0;
            if (bus.I_flush) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.I_valid) state <= S_EXEC;
                    end
                    S_EXEC: begin
                        if (!bus.I_alu_multiCycle) begin
                            state <= bus.I_valid ? S_EXEC : S_IDLE;
                        end else if (bus.I_alu_dataReady) begin
                            state <= S_IDLE;
                        end else begin
                            state <= S_WAIT;
`ifdef CEESPU_EXSEQ_TIMEOUT_EN
                            wait_cnt <= '0;
`endif
                        end
                    end
                    S_WAIT: begin
                        if (bus.I_alu_dataReady) begin
                            state <= S_IDLE;
                        end
`ifdef CEESPU_EXSEQ_TIMEOUT_EN
                        else if (wait_cnt == 4'(TIMEOUT - 1)) begin
                            state   <= S_IDLE;
                            timeout <= 1'b1;
                        end else begin
                            wait_cnt <= wait_cnt + 4'd1;
                        end
`endif
                    end
                    default: state <= S_IDLE;
                endcase
            end
            if (ready && bus.I_valid) begin
                aluop_hold <= bus.I_aluop;
                a_hold     <= bus.I_dataA;
                b_hold     <= bus.I_dataB;
                cin_hold   <= bus.I_Cin;
                rd_hold    <= bus.I_rd;
            end
            if (capture) begin
                wb_valid <= 1'b1;
                wb_rd    <= rd_hold;
                wb_data  <= bus.I_alu_result;
                wb_cout  <= bus.I_alu_Cout;
            end
        end
    end

    assign bus.O_ready     = ready;
    assign bus.O_stall     = !ready;
    assign bus.O_alu_aluop = aluop_hold;
    assign bus.O_alu_dataA = a_hold;
    assign bus.O_alu_dataB = b_hold;
    assign bus.O_alu_Cin   = cin_hold;
    assign bus.O_wb_valid  = wb_valid;
    assign bus.O_wb_rd     = wb_rd;
    assign bus.O_wb_data   = wb_data;
    assign bus.O_wb_Cout   = wb_cout;
`ifdef CEESPU_EXSEQ_TIMEOUT_EN
    assign bus.O_timeout   = timeout;
`else
    assign bus.O_timeout   = 1'b0;
`endif
endmodule

// File: tb/tb_ceespu_ex_sequencer.sv
// Bench for ceespu_ex_sequencer: directed cases then randomised op streams,
// checked against a transaction-level model of in-flight ops and writebacks.
`timescale 1ns/1ps
module tb_ceespu_ex_sequencer;
    localparam int         RD_W    = 5;
    localparam int         TIMEOUT = 15;
    localparam logic [3:0] OP_MUL  = 4'd9;

    typedef struct {
        logic [3:0]      op;
        logic [31:0]     a;
        logic [31:0]     b;
        logic            cin;
        logic [RD_W-1:0] rd;
        int              lat;
    } op_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ceespu_ex_sequencer_if #(.RD_W(RD_W)) bus ();
    ceespu_ex_sequencer #(.RD_W(RD_W), .TIMEOUT(TIMEOUT)) dut (
        .I_clk(clk),
        .I_rst(rst),
        .bus  (bus)
    );

    // ALU behaviour: {Cout, result}
    function automatic logic [32:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic cin);
        case (op)
            4'd0:    return {1'b0, a} + {1'b0, b} + 33'(cin);
            4'd1:    return {1'b0, a | b};
            4'd2:    return {1'b0, a & b};
            4'd3:    return {1'b0, a ^ b};
            4'd4:    return {1'b0, a - b};
            4'd6:    return {1'b0, a << b[4:0]};
            4'd9:    return {1'b0, a * b};
            default: return {1'b0, a};
        endcase
    endfunction

    logic [32:0] alu_out;
    assign alu_out              = alu_ref(bus.O_alu_aluop, bus.O_alu_dataA, bus.O_alu_dataB, bus.O_alu_Cin);
    assign bus.I_alu_result     = alu_out[31:0];
    assign bus.I_alu_Cout       = alu_out[32];
    assign bus.I_alu_multiCycle = (bus.O_alu_aluop == OP_MUL);

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model of the op currently owned by the sequencer and of the writeback port
    bit              inflight;
    op_t             inf;
    int              age;
    op_t             nxt;
    bit              drv_valid;
    bit              spurious;
    int              flush_pct;
    bit              exp_timeout;
    logic [RD_W-1:0] last_rd;
    logic [31:0]     last_data;
    logic            last_cout;

    function automatic op_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic cin, input logic [RD_W-1:0] rd, input int lat);
        op_t o;
        o.op = op; o.a = a; o.b = b; o.cin = cin; o.rd = rd; o.lat = lat;
        return o;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        case ($urandom_range(0, 5))
            0:       o.op = 4'd0;
            1:       o.op = 4'd1;
            2:       o.op = 4'd2;
            3:       o.op = 4'd3;
            4:       o.op = 4'd6;
            default: o.op = OP_MUL;
        endcase
        o.a   = $urandom;
        o.b   = $urandom;
        o.cin = 1'($urandom_range(0, 1));
        o.rd  = RD_W'($urandom);
        o.lat = $urandom_range(0, 5);
        return o;
    endfunction

    task automatic model_clear();
        inflight    = 1'b0;
        exp_timeout = 1'b0;
        last_rd     = '0;
        last_data   = '0;
        last_cout   = 1'b0;
    endtask

    // One clock: drive at negedge, check combinational outputs, advance model, check wb.
    task automatic step(input bit flush, output bit accepted);
        bit    mul, drdy, exp_ready, wb_exp;
        op_t   wb_op;
        logic [32:0] res;
        @(negedge clk);
        mul  = inflight && (inf.op == OP_MUL);
        drdy = mul ? (age == inf.lat) : (spurious && ($urandom_range(0, 3) == 0));
        bus.I_valid         = drv_valid;
        bus.I_aluop         = nxt.op;
        bus.I_dataA         = nxt.a;
        bus.I_dataB         = nxt.b;
        bus.I_Cin           = nxt.cin;
        bus.I_rd            = nxt.rd;
        bus.I_flush         = flush;
        bus.I_alu_dataReady = drdy;
        #1;
        exp_ready = !flush && (!inflight || !mul);
        chk("ready", bus.O_ready, exp_ready);
        chk("stall", bus.O_stall, !exp_ready);
        chk("timeout", bus.O_timeout, exp_timeout);
        if (inflight) begin
            chk("alu_op", bus.O_alu_aluop, inf.op);
            chk("alu_a", bus.O_alu_dataA, inf.a);
            chk("alu_b", bus.O_alu_dataB, inf.b);
            chk("alu_cin", bus.O_alu_Cin, inf.cin);
        end
        accepted = drv_valid && exp_ready;
        wb_exp   = 1'b0;
        wb_op    = inf;
        if (flush) begin
            inflight = 1'b0;
        end else if (inflight) begin
            if (!mul || drdy) begin
                wb_exp   = 1'b1;
                inflight = 1'b0;
            end
`ifdef CEESPU_EXSEQ_TIMEOUT_EN
            else if (age == TIMEOUT) begin
                inflight    = 1'b0;
                exp_timeout = 1'b1;
            end
`endif
            age++;
        end
        if (accepted) begin
            inflight = 1'b1;
            inf      = nxt;
            age      = 0;
        end
        @(posedge clk);
        #1;
        chk("wb_valid", bus.O_wb_valid, wb_exp);
        if (wb_exp) begin
            res       = alu_ref(wb_op.op, wb_op.a, wb_op.b, wb_op.cin);
            last_data = res[31:0];
            last_cout = res[32];
            last_rd   = wb_op.rd;
        end
        chk("wb_rd", bus.O_wb_rd, last_rd);
        chk("wb_data", bus.O_wb_data, last_data);
        chk("wb_cout", bus.O_wb_Cout, last_cout);
    endtask

    // Decode holds the op until the sequencer takes it.
    task automatic issue(input op_t op);
        bit acc;
        int n;
        nxt       = op;
        drv_valid = 1'b1;
        n         = 0;
        do begin
            step(($urandom_range(0, 99) < flush_pct), acc);
            n++;
        end while (!acc && n < 100);
        if (!acc) chk("accept_bound", 0, 1);
        drv_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst                 = 1'b1;
        drv_valid           = 1'b0;
        bus.I_valid         = 1'b0;
        bus.I_flush         = 1'b0;
        bus.I_alu_dataReady = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_ready", bus.O_ready, 1);
        chk("rst_alu_op", bus.O_alu_aluop, 0);
        chk("rst_alu_a", bus.O_alu_dataA, 0);
        chk("rst_alu_b", bus.O_alu_dataB, 0);
        chk("rst_alu_cin", bus.O_alu_Cin, 0);
        chk("rst_wb_valid", bus.O_wb_valid, 0);
        chk("rst_wb_rd", bus.O_wb_rd, 0);
        chk("rst_wb_data", bus.O_wb_data, 0);
        chk("rst_wb_cout", bus.O_wb_Cout, 0);
        chk("rst_timeout", bus.O_timeout, 0);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int n;
        bus.I_valid = 1'b0; bus.I_aluop = '0; bus.I_dataA = '0; bus.I_dataB = '0;
        bus.I_Cin = 1'b0; bus.I_rd = '0; bus.I_flush = 1'b0; bus.I_alu_dataReady = 1'b0;
        drv_valid = 1'b0; spurious = 1'b0; flush_pct = 0;
        nxt = mk(4'd0, 32'd0, 32'd0, 1'b0, '0, 0);
        inf = nxt;
        age = 0;
        model_clear();
        repeat (2) @(posedge clk);
        do_reset();

        // Add with carry-out, result two edges after accept
        issue(mk(4'd0, 32'hFFFF_FFFF, 32'd1, 1'b0, 5'd3, 0));
        step(1'b0, acc);
        chk("add_valid", bus.O_wb_valid, 1);
        chk("add_data", bus.O_wb_data, 32'h0);
        chk("add_cout", bus.O_wb_Cout, 1);
        chk("add_rd", bus.O_wb_rd, 3);
        step(1'b0, acc);

        // Back-to-back single-cycle ops
        issue(mk(4'd1, 32'h0F, 32'h03, 1'b0, 5'd1, 0));
        issue(mk(4'd3, 32'h0F, 32'h03, 1'b0, 5'd2, 0));
        chk("or_data", bus.O_wb_data, 32'h0F);
        issue(mk(4'd6, 32'h0F, 32'h03, 1'b0, 5'd4, 0));
        chk("xor_data", bus.O_wb_data, 32'h0C);
        step(1'b0, acc);
        chk("shl_data", bus.O_wb_data, 32'h78);
        chk("shl_valid", bus.O_wb_valid, 1);
        step(1'b0, acc);

        // Multiply with dataReady three cycles after EXEC; next op waits for IDLE
        issue(mk(OP_MUL, 32'd7, 32'd6, 1'b0, 5'd9, 3));
        nxt       = mk(4'd0, 32'd1, 32'd2, 1'b0, 5'd10, 0);
        drv_valid = 1'b1;
        n         = 0;
        do begin
            step(1'b0, acc);
            n++;
            if (n == 4) begin
                chk("mul_valid", bus.O_wb_valid, 1);
                chk("mul_data", bus.O_wb_data, 32'd42);
            end
        end while (!acc && n < 20);
        chk("mul_next_accept", n, 5);
        drv_valid = 1'b0;
        repeat (2) step(1'b0, acc);

        // Flush coincident with dataReady discards the result
        issue(mk(OP_MUL, 32'd5, 32'd5, 1'b0, 5'd11, 2));
        step(1'b0, acc);
        step(1'b0, acc);
        step(1'b1, acc);
        chk("flush_no_wb", bus.O_wb_valid, 0);
        repeat (2) step(1'b0, acc);

        // Reset in the middle of a long WAIT
        issue(mk(OP_MUL, 32'd3, 32'd4, 1'b1, 5'd12, 1000));
        repeat (3) step(1'b0, acc);
        do_reset();
        step(1'b0, acc);

`ifdef CEESPU_EXSEQ_TIMEOUT_EN
        // dataReady never arrives: abort after TIMEOUT WAIT cycles
        issue(mk(OP_MUL, 32'd3, 32'd5, 1'b0, 5'd7, 1000));
        repeat (20) step(1'b0, acc);
        chk("timeout_flag", bus.O_timeout, 1);
        chk("timeout_no_wb", bus.O_wb_valid, 0);
        do_reset();
`endif

        // Random streams with gaps, spurious dataReady and occasional flush
        spurious  = 1'b1;
        flush_pct = 5;
        for (int i = 0; i < 300; i++) begin
            issue(rand_op());
            repeat ($urandom_range(0, 2)) step(($urandom_range(0, 99) < flush_pct), acc);
        end
        flush_pct = 0;
        repeat (10) step(1'b0, acc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ceespu_ex_sequencer.md
Name: ceespu_ex_sequencer

Overview:
- Execute-stage sequencer on the initiator side of the ALU's multi-cycle handshake.
- Accepts decoded ops from the decode stage through a valid/ready handshake and holds operands stable at the ALU inputs.
- Stalls upstream while the ALU reports a multi-cycle op, waits for the ALU's data-ready strobe, then presents a registered writeback packet.
- Single-cycle ops stream at one per clock.

Parameters:
- RD_W, 5, destination register index width.
- TIMEOUT, 15, maximum WAIT cycles before abort; used only with the optional feature.

Ports:
- I_clk  in  1  clock
- I_rst  in  1  reset
- I_valid  in  1  decode presents an op
- O_ready  out  1  sequencer accepts the op this cycle
- I_aluop  in  4  ALU opcode
- I_dataA  in  32  operand A
- I_dataB  in  32  operand B
- I_Cin  in  1  carry in
- I_rd  in  RD_W  destination register
- I_flush  in  1  discard the in-flight op
- O_alu_dataA  out  32  to ALU operand A
- O_alu_dataB  out  32  to ALU operand B
- O_alu_Cin  out  1  to ALU carry in
- O_alu_aluop  out  4  to ALU opcode
- I_alu_multiCycle  in  1  ALU: current op is multi-cycle
- I_alu_dataReady  in  1  ALU: multi-cycle result valid this cycle
- I_alu_result  in  32  ALU result
- I_alu_Cout  in  1  ALU carry out
- O_stall  out  1  upstream stall, equal to ~O_ready
- O_wb_valid  out  1  writeback packet valid, one-cycle pulse per op
- O_wb_rd  out  RD_W  writeback destination
- O_wb_data  out  32  writeback data
- O_wb_Cout  out  1  writeback carry
- O_timeout  out  1  sticky abort flag

Behaviour:
- Reset: I_rst is synchronous, active-high; clock is I_clk. Reset forces state IDLE and clears all hold registers. O_alu_* = 0 (aluop 0 is add). O_wb_valid = 0, O_wb_rd = 0, O_wb_data = 0, O_wb_Cout = 0, O_timeout = 0. Reset in any state, including mid-WAIT, aborts the op with no writeback.
- State IDLE:
  - O_ready = 1.
  - On I_valid: load hold regs (aluop, A, B, Cin, rd) and go to EXEC.
- ALU drive: O_alu_* always come directly from the hold regs. Operands stay constant for the whole EXEC/WAIT residency.
- State EXEC (ALU sees the op):
  - If I_alu_multiCycle = 0: O_ready = 1. At the clock edge, capture result, Cout and rd into wb regs and set O_wb_valid = 1.
    - If I_valid: load the next op into hold regs and stay in EXEC.
    - Otherwise go to IDLE.
  - If I_alu_multiCycle = 1: O_ready = 0. Go to WAIT, or capture immediately if I_alu_dataReady is already 1.
- State WAIT:
  - O_ready = 0; hold regs frozen.
  - On I_alu_dataReady = 1: capture into wb regs, set O_wb_valid = 1, go to IDLE.
  - The new op is accepted only in the next cycle (IDLE), so there is no back-to-back after a multiply.
- Latency:
  - Op accepted at edge N: O_wb_valid is high in the cycle after edge N+1 for single-cycle ops.
  - For multi-cycle ops: O_wb_valid is high in the cycle after the edge that samples dataReady.
- O_wb_valid: high for exactly one cycle per completed op. O_wb_* data hold their last value when valid = 0.
- Flush:
  - I_flush has priority over accept and capture: state goes to IDLE, O_wb_valid = 0 next cycle, and O_ready = 0 during the flush cycle.
  - Flush coincident with dataReady: the result is discarded.
  - Flush in IDLE: no effect.
- I_alu_dataReady outside WAIT/EXEC-multiCycle is ignored.
- I_valid with O_ready = 0 is ignored; decode must hold the op.

Optional Feature:
- Macro CEESPU_EXSEQ_TIMEOUT_EN.
- Defined:
  - 4-bit wait counter, cleared on entry to WAIT and incremented each WAIT cycle.
  - When the count reaches TIMEOUT without dataReady: go to IDLE, no writeback, O_timeout = 1.
  - O_timeout stays set until I_rst.
- Undefined: WAIT lasts indefinitely; O_timeout is tied to 0 and no counter logic is present.

Test Plan:
- Reset, then valid add with aluop = 0, A = 0xFFFFFFFF, B = 1, Cin = 0, rd = 3 -> O_wb_valid pulse 2 edges after accept, O_wb_data = 0, O_wb_Cout = 1, O_wb_rd = 3.
- Three back-to-back ops: OR (aluop = 1), XOR (aluop = 3), SHL (aluop = 6) with A = 0x0F, B = 0x03 -> O_ready held at 1. O_wb_valid is high for three consecutive cycles with data 0x0F, 0x0C, 0x78.
- MUL (aluop = 9), A = 7, B = 6; ALU model asserts multiCycle and asserts dataReady 3 cycles later -> O_stall = 1 throughout and the ALU operands stay stable. One O_wb_valid with data 42; next op accepted only after returning to IDLE.
- MUL in WAIT, I_flush asserted in the same cycle as dataReady -> no O_wb_valid pulse; state IDLE and O_ready = 1 on the following cycle.
- I_rst asserted mid-WAIT -> all outputs return to reset values next cycle and no writeback occurs.
- With CEESPU_EXSEQ_TIMEOUT_EN and TIMEOUT = 15, MUL whose dataReady never arrives -> after 15 WAIT cycles state returns to IDLE, O_timeout = 1 (sticky), O_wb_valid stays 0.
